// File: rtl/virtio_available_ring_handler_multi.sv
// Multi-queue virtio available ring handler: tracks avail-index writes and guest notifications, round-robin issues ring reads.
// Optional VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN adds stats_ids, per-queue saturating sums of accepted READ_IDS lengths.
module virtio_available_ring_handler_multi #(
  parameter int QUEUES                 = 4,
  parameter int MAX_BURST_TRANSACTIONS = 16,
  parameter int THRESHOLD_HIGH         = 1024,
  parameter int THRESHOLD_LOW          = 16,
  localparam int QW = (QUEUES > 1) ? $clog2(QUEUES) : 1
) (
  input  logic          aclk,
  input  logic          areset_n,
  input  logic          configure_tvalid,
  output logic          configure_tready,
  input  logic [QW-1:0] configure_tid,
  input  logic [1:0]    configure_tdata,
  input  logic          notify_tvalid,
  output logic          notify_tready,
  input  logic [QW-1:0] notify_tid,
  input  logic          rx_tvalid,
  output logic          rx_tready,
  input  logic [QW-1:0] rx_tid,
  input  logic [15:0]   rx_tdata,
  output logic          tx_tvalid,
  input  logic          tx_tready,
  output logic [1:0]    tx_tid,
  output logic [QW-1:0] tx_tdest,
  output logic [31:0]   tx_tdata,
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
  output logic [QUEUES*32-1:0] stats_ids,
`endif
  output logic [1:0]    dbg_state
);

  // Handshakes: a beat transfers on a cycle where valid && ready. Once tx_tvalid rises, tx_tid,
  // tx_tdest and tx_tdata hold until that cycle. The input streams are always ready out of reset.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EVENT_IDX, S_SETTLE} state_t;

  localparam logic [1:0]  TID_IDS = 2'd0;
  localparam logic [1:0]  TID_IDX = 2'd1;
  localparam logic [1:0]  TID_EVT = 2'd2;
  localparam logic [15:0] MAX_LEN = 16'(MAX_BURST_TRANSACTIONS);
  localparam logic [15:0] TH_HIGH = 16'(THRESHOLD_HIGH);
  localparam logic [15:0] TH_LOW  = 16'(THRESHOLD_LOW);

  state_t        state_q, state_d;
  logic [QW-1:0] last_grant_q, last_grant_d;
  logic          ready_q;
  logic          tx_tvalid_q, tx_tvalid_d;
  logic [1:0]    tx_tid_q, tx_tid_d;
  logic [QW-1:0] tx_tdest_q, tx_tdest_d;
  logic [31:0]   tx_tdata_q, tx_tdata_d;

  logic [15:0] wp_q[QUEUES], wp_d[QUEUES];
  logic [15:0] rp_q[QUEUES], rp_d[QUEUES];
  logic [15:0] diff_q[QUEUES], diff_d[QUEUES];
  logic [QUEUES-1:0] notif_q, notif_d, supp_q, supp_d;
  logic [QUEUES-1:0] event_idx_q, event_idx_d, enable_q, enable_d;
  logic [QUEUES-1:0] notify_hit_q, notify_hit_d;
  logic [QUEUES-1:0] pending;

  logic          ids_accept, idx_accept, found;
  logic [QW-1:0] grant, cand;
  logic [15:0]   len_v;

`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
  logic [31:0] stats_q[QUEUES], stats_d[QUEUES];
  logic [32:0] sum_v;
`endif

  assign configure_tready = ready_q;
  assign notify_tready    = ready_q;
  assign rx_tready        = ready_q;
  assign tx_tvalid        = tx_tvalid_q;
  assign tx_tid           = tx_tid_q;
  assign tx_tdest         = tx_tdest_q;
  assign tx_tdata         = tx_tdata_q;
  assign dbg_state        = state_q;

  always_comb begin
    for (int q = 0; q < QUEUES; q++) begin
      pending[q] = enable_q[q] && ((notif_q[q] && !supp_q[q]) || (diff_q[q] != 16'd0));
    end
  end

  // Search starts at the queue after the last grant so every queue gets a turn.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 1; i <= QUEUES; i++) begin
      cand = QW'((int'(last_grant_q) + i) % QUEUES);
      if (!found && pending[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tx_tvalid_d  = tx_tvalid_q;
    tx_tid_d     = tx_tid_q;
    tx_tdest_d   = tx_tdest_q;
    tx_tdata_d   = tx_tdata_q;
    ids_accept   = 1'b0;
    idx_accept   = 1'b0;
    len_v        = (diff_q[grant] > MAX_LEN) ? MAX_LEN : diff_q[grant];
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_ISSUE;
          last_grant_d = grant;
          tx_tvalid_d  = 1'b1;
          tx_tdest_d   = grant;
          if (notif_q[grant] && !supp_q[grant]) begin
            tx_tid_d   = TID_IDX;
            tx_tdata_d = '0;
          end else begin
            tx_tid_d   = TID_IDS;
            tx_tdata_d = {len_v, rp_q[grant]};
          end
        end
      end
      S_ISSUE: begin
        if (tx_tready) begin
          if (tx_tid_q == TID_IDS) begin
            ids_accept  = 1'b1;
            tx_tvalid_d = 1'b0;
            state_d     = S_SETTLE;
          end else begin
            idx_accept = 1'b1;
            if (event_idx_q[tx_tdest_q]) begin
              tx_tid_d   = TID_EVT;
              tx_tdata_d = '0;
              state_d    = S_EVENT_IDX;
            end else begin
              tx_tvalid_d = 1'b0;
              state_d     = S_SETTLE;
            end
          end
        end
      end
      S_EVENT_IDX: begin
        if (tx_tready) begin
          tx_tvalid_d = 1'b0;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Disable is applied last so it overrides every other update to that queue.
  always_comb begin
    notif_d      = notif_q;
    supp_d       = supp_q;
    event_idx_d  = event_idx_q;
    enable_d     = enable_q;
    notify_hit_d = '0;
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
    sum_v = '0;
`endif
    for (int q = 0; q < QUEUES; q++) begin
      wp_d[q]   = wp_q[q];
      rp_d[q]   = rp_q[q];
      diff_d[q] = wp_q[q] - rp_q[q];
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
      stats_d[q] = stats_q[q];
`endif
      notify_hit_d[q] = ready_q && notify_tvalid && (notify_tid == QW'(q)) && enable_q[q];
      if (ready_q && rx_tvalid && (rx_tid == QW'(q)) && enable_q[q]) wp_d[q] = rx_tdata;
      if (ids_accept && (tx_tdest_q == QW'(q)) && enable_q[q]) begin
        rp_d[q] = rp_q[q] + tx_tdata_q[31:16];
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
        sum_v      = {1'b0, stats_q[q]} + 33'(tx_tdata_q[31:16]);
        stats_d[q] = sum_v[32] ? 32'hFFFF_FFFF : sum_v[31:0];
`endif
      end
      if (idx_accept && (tx_tdest_q == QW'(q))) notif_d[q] = 1'b0;
      if (notify_hit_q[q] && enable_q[q]) notif_d[q] = 1'b1;
      if (!supp_q[q] && (diff_q[q] >= TH_HIGH)) supp_d[q] = 1'b1;
      else if (supp_q[q] && (diff_q[q] <= TH_LOW)) supp_d[q] = 1'b0;
      if (ready_q && configure_tvalid && (configure_tid == QW'(q))) begin
        event_idx_d[q] = configure_tdata[0];
        enable_d[q]    = configure_tdata[1];
        if (enable_q[q] && !configure_tdata[1]) begin
          wp_d[q]         = '0;
          rp_d[q]         = '0;
          notif_d[q]      = 1'b0;
          supp_d[q]       = 1'b0;
          notify_hit_d[q] = 1'b0;
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
          stats_d[q] = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= QW'(QUEUES - 1);
      ready_q      <= 1'b0;
      tx_tvalid_q  <= 1'b0;
      tx_tid_q     <= '0;
      tx_tdest_q   <= '0;
      tx_tdata_q   <= '0;
      wp_q         <= '{default: '0};
      rp_q         <= '{default: '0};
      diff_q       <= '{default: '0};
      notif_q      <= '0;
      supp_q       <= '0;
      event_idx_q  <= '0;
      enable_q     <= '0;
      notify_hit_q <= '0;
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
      stats_q      <= '{default: '0};
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ready_q      <= 1'b1;
      tx_tvalid_q  <= tx_tvalid_d;
      tx_tid_q     <= tx_tid_d;
      tx_tdest_q   <= tx_tdest_d;
      tx_tdata_q   <= tx_tdata_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      diff_q       <= diff_d;
      notif_q      <= notif_d;
      supp_q       <= supp_d;
      event_idx_q  <= event_idx_d;
      enable_q     <= enable_d;
      notify_hit_q <= notify_hit_d;
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
      stats_q      <= stats_d;
`endif
    end
  end

`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
  always_comb begin
    for (int q = 0; q < QUEUES; q++) stats_ids[q*32 +: 32] = stats_q[q];
  end
`endif

endmodule

// File: tb/tb_virtio_available_ring_handler_multi.sv
// Self-checking bench for virtio_available_ring_handler_multi: vector table, hand sequences, randomized rx traffic.
module tb_virtio_available_ring_handler_multi;

  localparam int QW = 2;
  localparam int W  = 36;

  typedef struct {
    int          q;
    logic [15:0] wp;
    int          exp_n;
  } vec_t;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic          configure_tvalid, configure_tready;
  logic [QW-1:0] configure_tid;
  logic [1:0]    configure_tdata;
  logic          notify_tvalid, notify_tready;
  logic [QW-1:0] notify_tid;
  logic          rx_tvalid, rx_tready;
  logic [QW-1:0] rx_tid;
  logic [15:0]   rx_tdata;
  logic          tx_tvalid, tx_tready;
  logic [1:0]    tx_tid;
  logic [QW-1:0] tx_tdest;
  logic [31:0]   tx_tdata;
  logic [1:0]    dbg_state;
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
  logic [4*32-1:0] stats_ids;
`endif

  virtio_available_ring_handler_multi dut (
    .aclk(aclk), .areset_n(areset_n),
    .configure_tvalid(configure_tvalid), .configure_tready(configure_tready),
    .configure_tid(configure_tid), .configure_tdata(configure_tdata),
    .notify_tvalid(notify_tvalid), .notify_tready(notify_tready), .notify_tid(notify_tid),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tid(rx_tid), .rx_tdata(rx_tdata),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tid(tx_tid), .tx_tdest(tx_tdest),
    .tx_tdata(tx_tdata),
`ifdef VIRTIO_AVAILABLE_RING_HANDLER_STATS_EN
    .stats_ids(stats_ids),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rand_tready = 1'b0;
  logic [W-1:0] log_q[$];
  logic [W-1:0] exp_q[$];
  vec_t        vecs[7];

  // every accepted request, as {tid, dest, length, offset}
  always @(posedge aclk) begin
    if (areset_n && tx_tvalid && tx_tready)
      log_q.push_back({tx_tid, tx_tdest, tx_tdata[31:16], tx_tdata[15:0]});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    if (rand_tready) tx_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    configure_tvalid = 1'b0; configure_tid = '0; configure_tdata = '0;
    notify_tvalid = 1'b0; notify_tid = '0;
    rx_tvalid = 1'b0; rx_tid = '0; rx_tdata = '0;
    tx_tready = 1'b1;
    rand_tready = 1'b0;
    repeat (3) tick();
    areset_n = 1'b1;
    tick();
  endtask

  // driver tasks: each presents one beat for one clock edge
  task automatic cfg(input int q, input logic en, input logic evt);
    configure_tvalid = 1'b1; configure_tid = QW'(q); configure_tdata = {en, evt};
    tick();
    configure_tvalid = 1'b0;
  endtask

  task automatic rx_beat(input int q, input logic [15:0] wp);
    rx_tvalid = 1'b1; rx_tid = QW'(q); rx_tdata = wp;
    tick();
    rx_tvalid = 1'b0;
  endtask

  task automatic notify_beat(input int q);
    notify_tvalid = 1'b1; notify_tid = QW'(q);
    tick();
    notify_tvalid = 1'b0;
  endtask

  task automatic wait_tvalid(input int budget);
    int n = 0;
    while (!tx_tvalid && n < budget) begin tick(); n++; end
    check("wait_tvalid", 64'(tx_tvalid), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 6 && n < budget) begin
      tick(); n++;
      if (!tx_tvalid) quiet++; else quiet = 0;
    end
    check("wait_idle", 64'(quiet >= 6), 64'd1);
  endtask

  // reference model: the ids between rp and wp, cut into bursts of at most 16
  task automatic model_ids(input int q, input logic [15:0] rp, input logic [15:0] wp);
    logic [15:0] r;
    logic [15:0] rem;
    logic [15:0] len;
    r = rp;
    rem = wp - rp;
    while (rem != 16'd0) begin
      len = (rem > 16'd16) ? 16'd16 : rem;
      exp_q.push_back({2'd0, QW'(q), len, r});
      r = r + len;
      rem = rem - len;
    end
  endtask

  task automatic compare_log(input string name, input int mark);
    check($sformatf("%s count", name), 64'(log_q.size() - mark), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (mark + i < log_q.size()) check($sformatf("%s req%0d", name, i), 64'(log_q[mark + i]), 64'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    int mark;
    logic [15:0] rp_m[4];
    logic [15:0] wp_m[4];
    int cum, cum_at_idx, idx_count, qq;
    logic [W-1:0] r;

    vecs[0] = '{q: 1, wp: 16'd5,  exp_n: 1};
    vecs[1] = '{q: 0, wp: 16'd40, exp_n: 3};
    vecs[2] = '{q: 3, wp: 16'd16, exp_n: 1};
    vecs[3] = '{q: 2, wp: 16'd17, exp_n: 2};
    vecs[4] = '{q: 0, wp: 16'd72, exp_n: 2};
    vecs[5] = '{q: 1, wp: 16'd5,  exp_n: 0};
    vecs[6] = '{q: 2, wp: 16'd33, exp_n: 1};

    // reset values, sampled while reset is held and just after release
    areset_n = 1'b0;
    configure_tvalid = 1'b0; configure_tid = '0; configure_tdata = '0;
    notify_tvalid = 1'b0; notify_tid = '0;
    rx_tvalid = 1'b0; rx_tid = '0; rx_tdata = '0;
    tx_tready = 1'b1;
    repeat (3) tick();
    check("reset readies", 64'({configure_tready, notify_tready, rx_tready}), 64'd0);
    check("reset tx", 64'({tx_tvalid, tx_tid, tx_tdest, tx_tdata}), 64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    areset_n = 1'b1;
    tick();
    check("readies out of reset", 64'({configure_tready, notify_tready, rx_tready}), 64'b111);

    // vector table: wp writes with the bursts the model predicts
    for (int q = 0; q < 4; q++) begin cfg(q, 1'b1, 1'b0); rp_m[q] = '0; end
    for (int v = 0; v < 7; v++) begin
      mark = log_q.size();
      rx_beat(vecs[v].q, vecs[v].wp);
      wait_idle(500);
      check($sformatf("vec%0d n", v), 64'(log_q.size() - mark), 64'(vecs[v].exp_n));
      model_ids(vecs[v].q, rp_m[vecs[v].q], vecs[v].wp);
      rp_m[vecs[v].q] = vecs[v].wp;
      compare_log($sformatf("vec%0d", v), mark);
    end

    // rx latency: beat at edge N, tvalid after N+2
    do_reset();
    cfg(1, 1'b1, 1'b0);
    tx_tready = 1'b0;
    rx_beat(1, 16'd5);
    check("rx lat N", 64'(tx_tvalid), 64'd0);
    tick();
    check("rx lat N+1", 64'(tx_tvalid), 64'd0);
    tick();
    check("rx lat N+2", 64'(tx_tvalid), 64'd1);
    check("rx lat fields", 64'({tx_tid, tx_tdest, tx_tdata}), 64'({2'd0, 2'd1, 16'd5, 16'd0}));
    tx_tready = 1'b1;
    wait_idle(50);

    // notify with event_idx: READ_IDX then READ_USED_EVENT back-to-back, then nothing
    do_reset();
    cfg(2, 1'b1, 1'b1);
    tx_tready = 1'b0;
    mark = log_q.size();
    notify_beat(2);
    check("ntf lat N", 64'(tx_tvalid), 64'd0);
    tick();
    check("ntf lat N+1", 64'(tx_tvalid), 64'd0);
    tick();
    check("ntf lat N+2", 64'(tx_tvalid), 64'd1);
    check("ntf idx fields", 64'({tx_tid, tx_tdest}), 64'({2'd1, 2'd2}));
    tx_tready = 1'b1;
    tick();
    check("evt valid", 64'(tx_tvalid), 64'd1);
    check("evt fields", 64'({tx_tid, tx_tdest, tx_tdata}), 64'({2'd2, 2'd2, 32'd0}));
    tick();
    check("evt done", 64'(tx_tvalid), 64'd0);
    wait_idle(50);
    check("ntf total reqs", 64'(log_q.size() - mark), 64'd2);

    // four queues: stall holds fields, 2-cycle gap between grants, order 0..3
    do_reset();
    for (int q = 0; q < 4; q++) cfg(q, 1'b1, 1'b0);
    tx_tready = 1'b0;
    mark = log_q.size();
    for (int q = 0; q < 4; q++) rx_beat(q, 16'd1);
    wait_tvalid(20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d", i), 64'({tx_tvalid, tx_tid, tx_tdest, tx_tdata}),
            64'({1'b1, 2'd0, 2'd0, 16'd1, 16'd0}));
    end
    tx_tready = 1'b1;
    tick();
    check("gap settle", 64'(tx_tvalid), 64'd0);
    tick();
    check("gap idle", 64'(tx_tvalid), 64'd0);
    tick();
    check("gap next", 64'({tx_tvalid, tx_tdest}), 64'({1'b1, 2'd1}));
    wait_idle(100);
    for (int q = 0; q < 4; q++) model_ids(q, 16'd0, 16'd1);
    compare_log("rr order", mark);

    // suppression: large backlog holds the notification until diff <= 16
    do_reset();
    cfg(0, 1'b1, 1'b0);
    mark = log_q.size();
    rx_beat(0, 16'd1100);
    repeat (5) tick();
    notify_beat(0);
    wait_idle(3000);
    cum = 0; cum_at_idx = 0; idx_count = 0;
    for (int i = mark; i < log_q.size(); i++) begin
      r = log_q[i];
      if (r[35:34] == 2'd1) begin idx_count++; cum_at_idx = cum; end
      else cum += int'(r[31:16]);
    end
    check("supp idx count", 64'(idx_count), 64'd1);
    check("supp ids total", 64'(cum), 64'd1100);
    check("supp idx after drain", 64'(cum_at_idx >= 1084), 64'd1);

    // wrap: rp at 0xFFFE, wp 0x0002
    do_reset();
    cfg(3, 1'b1, 1'b0);
    rx_beat(3, 16'hFFFE);
    wait_idle(20000);
    mark = log_q.size();
    rx_beat(3, 16'h0002);
    wait_idle(100);
    exp_q.push_back({2'd0, 2'd3, 16'd4, 16'hFFFE});
    compare_log("wrap", mark);
    mark = log_q.size();
    rx_beat(3, 16'h0003);
    wait_idle(100);
    exp_q.push_back({2'd0, 2'd3, 16'd1, 16'h0002});
    compare_log("after wrap", mark);

    // disable of the granted queue mid-ISSUE: request completes, rp update dropped
    do_reset();
    cfg(1, 1'b1, 1'b0);
    tx_tready = 1'b0;
    mark = log_q.size();
    rx_beat(1, 16'd10);
    wait_tvalid(20);
    cfg(1, 1'b0, 1'b0);
    tick();
    check("dis held", 64'({tx_tvalid, tx_tdest, tx_tdata}), 64'({1'b1, 2'd1, 16'd10, 16'd0}));
    tx_tready = 1'b1;
    wait_idle(50);
    exp_q.push_back({2'd0, 2'd1, 16'd10, 16'd0});
    compare_log("dis complete", mark);
    cfg(1, 1'b1, 1'b0);
    mark = log_q.size();
    rx_beat(1, 16'd3);
    wait_idle(100);
    exp_q.push_back({2'd0, 2'd1, 16'd3, 16'd0});
    compare_log("reenable", mark);

    // reset mid-operation: tvalid drops, nothing replayed
    do_reset();
    cfg(0, 1'b1, 1'b0);
    tx_tready = 1'b0;
    rx_beat(0, 16'd5);
    wait_tvalid(20);
    areset_n = 1'b0;
    tick();
    check("mid reset tvalid", 64'(tx_tvalid), 64'd0);
    areset_n = 1'b1;
    tx_tready = 1'b1;
    mark = log_q.size();
    repeat (10) tick();
    check("no replay", 64'(log_q.size() - mark), 64'd0);

    // randomized rx traffic with random backpressure
    do_reset();
    for (int q = 0; q < 4; q++) begin cfg(q, 1'b1, 1'b0); rp_m[q] = '0; wp_m[q] = '0; end
    mark = log_q.size();
    rand_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      qq = int'($urandom_range(0, 3));
      wp_m[qq] = wp_m[qq] + 16'($urandom_range(0, 200));
      rx_beat(qq, wp_m[qq]);
      repeat ($urandom_range(0, 4)) tick();
    end
    rand_tready = 1'b0;
    tx_tready = 1'b1;
    wait_idle(5000);
    for (int i = mark; i < log_q.size(); i++) begin
      r = log_q[i];
      qq = int'(r[33:32]);
      check($sformatf("rnd%0d tid", i - mark), 64'(r[35:34]), 64'd0);
      check($sformatf("rnd%0d off", i - mark), 64'(r[15:0]), 64'(rp_m[qq]));
      check($sformatf("rnd%0d len ok", i - mark), 64'(r[31:16] >= 16'd1 && r[31:16] <= 16'd16), 64'd1);
      rp_m[qq] = rp_m[qq] + r[31:16];
    end
    for (int q = 0; q < 4; q++) check($sformatf("rnd q%0d drained", q), 64'(rp_m[q]), 64'(wp_m[q]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
